// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half-adder cells plus a carry OR, iterated LSB-first.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow output ovf.

module serial_adder_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic            carry;
    logic [CW-1:0]   bit_cnt;

    logic s1;
    logic c1;
    logic s;
    logic c2;
    logic carry_next;

    serial_adder_ha u_ha_ab (.a(a_sr[0]), .b(b_sr[0]), .s(s1), .c(c1));
    serial_adder_ha u_ha_c  (.a(s1),      .b(carry),   .s(s),  .c(c2));

    assign carry_next = c1 | c2;

    // Handshakes: a transfer happens on a clk edge where valid && ready are both high.
    // Ready/valid are pure decodes of the state register, so no input reaches an output.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= op_a;
                        b_sr    <= op_b;
                        carry   <= cin;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= {s, sum[WIDTH-1:1]};
                    carry <= carry_next;
                    // The final bit: carry still holds the carry into the MSB here.
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        state   <= DONE;
                        bit_cnt <= '0;
                        cout    <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf     <= carry ^ carry_next;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder (WIDTH=8) against hand-computed results.
module tb_serial_adder;
    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf_obs;

    int n_tests = 0;
    int n_fail  = 0;
    int n_got   = 0;
    int n_push  = 0;

    logic [EW-1:0] exp_q[$];

    // Clock and reset-independent watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drop the ovf bit from an expected {ovf, cout, sum} when the feature is not built.
    function automatic logic [EW-1:0] mask_ovf(input logic [EW-1:0] x);
`ifdef SERIAL_ADDER_OVF_EN
        return x;
`else
        return {1'b0, x[EW-2:0]};
`endif
    endfunction

    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic c);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return mask_ovf({v, full});
    endfunction

    task automatic expect_result(input logic [EW-1:0] x);
        exp_q.push_back(mask_ovf(x));
        n_push++;
    endtask

    // Driver: waits for in_ready, presents one operand set, returns 1ns after the accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
        op_a     = a;
        op_b     = b;
        cin      = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = WIDTH'($urandom_range(0, 255));
        op_b     = WIDTH'($urandom_range(0, 255));
        cin      = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard side: waits for a result handshake, compares it, reports cycles waited.
    task automatic collect(input bit rand_ready, output int lat);
        logic [EW-1:0] e;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (in_ready && out_valid) check("ready_valid_excl", 64'(1), 64'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({ovf_obs, cout, sum}), 64'(e));
                end
                n_got++;
                break;
            end
            if (lat >= 300) begin
                check("result_timeout", 64'(out_valid), 64'(1));
                break;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int lat;
        int w;

        // Reset with in_valid asserted: no capture, outputs cleared
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op_a      = 8'h55;
        op_b      = 8'hAA;
        cin       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'(1));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_sum", 64'(sum), 64'(0));
            check("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
            check("rst_ovf", 64'(ovf), 64'(0));
`endif
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(in_ready), 64'(1));

        // Basic add and latency with out_ready held high
        out_ready = 1'b1;
        expect_result({1'b0, 1'b0, 8'h4B});
        send(8'h3C, 8'h0F, 1'b0);
        collect(1'b0, lat);
        check("basic_latency", 64'(lat), 64'(WIDTH + 1));

        // Full carry chain and signed overflow
        expect_result({1'b0, 1'b1, 8'h00});
        send(8'hFF, 8'h00, 1'b1);
        collect(1'b0, lat);
        expect_result({1'b1, 1'b0, 8'h80});
        send(8'h7F, 8'h01, 1'b0);
        collect(1'b0, lat);

        // Backpressure: result held, new operands ignored
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_result({1'b0, 1'b1, 8'h00});
        send(8'hA5, 8'h5A, 1'b1);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b1;
        op_a     = 8'h11;
        op_b     = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_ready", 64'(in_ready), 64'(0));
            check("bp_hold_sum", 64'({cout, sum}), 64'({1'b1, 8'h00}));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect(1'b0, lat);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'(1));
        check("bp_release_out_valid", 64'(out_valid), 64'(0));
        check("bp_result_kept", 64'({cout, sum}), 64'({1'b1, 8'h00}));
        repeat (WIDTH + 3) @(negedge clk);
        check("bp_no_capture", 64'(out_valid), 64'(0));

        // Reset in the middle of RUN discards the operation
        send(8'hF0, 8'h0F, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_sum", 64'({cout, sum}), 64'(0));
        expect_result({1'b0, 1'b0, 8'h02});
        send(8'h01, 8'h01, 1'b0);
        collect(1'b0, lat);

        // Random operands with random out_ready
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             c;
            a = WIDTH'($urandom_range(0, 255));
            b = WIDTH'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, c));
            n_push++;
            send(a, b, c);
            collect(1'b1, lat);
        end

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        check("result_count", 64'(n_got), 64'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
